// File: rtl/cache_ctrl_wt_pkg.sv
// cache_pkg: shared types and constants for the write-through cache slice.
//   state_t   : controller FSM encoding {IDLE, REFILL, WRITE}
//   TAG_W     : tag bits = ADDR - INDEX_W - OFF_W
//   OFF_W     : word offset bits within a 4-word line
//   LINES     : number of cache lines
//   get_tag / get_index : address field extraction for the default geometry
package cache_pkg;

    localparam int unsigned ADDR_W_DEF  = 10;
    localparam int unsigned WIDTH_DEF   = 32;
    localparam int unsigned INDEX_W_DEF = 5;

    localparam int unsigned OFF_W = 2;
    localparam int unsigned TAG_W = ADDR_W_DEF - INDEX_W_DEF - OFF_W;
    localparam int unsigned LINES = 1 << INDEX_W_DEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } state_t;

    function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W_DEF-1:0] addr);
        return addr[ADDR_W_DEF-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W_DEF-1:0] get_index(input logic [ADDR_W_DEF-1:0] addr);
        return addr[OFF_W +: INDEX_W_DEF];
    endfunction

endpackage

// File: rtl/cache_ctrl_wt_if.sv
// cache_ctrl_wt_if: CPU load/store port plus data_mem refill/store port.
//   slave  : the cache controller (consumes CPU requests, drives data_mem)
//   master : the environment (CPU driving requests, data_mem answering)
interface cache_ctrl_wt_if #(
    parameter int unsigned ADDR  = 10,
    parameter int unsigned WIDTH = 32
);
    // CPU side
    logic             cpu_read;
    logic             cpu_write;
    logic [ADDR-1:0]  cpu_addr;
    logic [WIDTH-1:0] cpu_wdata;
    logic [WIDTH-1:0] cpu_rdata;
    logic             stall;
    // data_mem side
    logic             mem_read;
    logic             mem_write;
    logic [ADDR-1:0]  mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [1:0]       mem_counter;
    logic             mem_ready;
    logic [WIDTH-1:0] mem_rdata;

    modport slave (
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_ready, mem_rdata,
        output cpu_rdata, stall, mem_read, mem_write, mem_addr, mem_wdata, mem_counter
    );

    modport master (
        output cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_ready, mem_rdata,
        input  cpu_rdata, stall, mem_read, mem_write, mem_addr, mem_wdata, mem_counter
    );
endinterface

// File: rtl/cache_ctrl_wt_line_array.sv
// cache_line_array: valid vector, tag RAM and data RAM of a direct-mapped cache.
//   clk, rst          : clock; rst asynchronously clears every valid bit only
//   rd_index/tag/off  : combinational lookup -> rd_data (line word), rd_hit
//   wr_en             : write wr_data into data[wr_index][wr_offset]
//   wr_set_valid      : with wr_en, also store wr_tag and set valid[wr_index]
module cache_line_array
    import cache_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_W_DEF-1:0] rd_index,
    input  logic [TAG_W-1:0]       rd_tag,
    input  logic [OFF_W-1:0]       rd_offset,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_hit,
    input  logic                   wr_en,
    input  logic [INDEX_W_DEF-1:0] wr_index,
    input  logic [OFF_W-1:0]       wr_offset,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   wr_set_valid,
    input  logic [TAG_W-1:0]       wr_tag
);

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_ram  [LINES];
    // Flat word array addressed by {index, offset}
    logic [WIDTH-1:0] data_ram [LINES << OFF_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en && wr_set_valid) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag and data contents survive reset; only valid bits gate their use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_ram[{wr_index, wr_offset}] <= wr_data;
        end
        if (wr_en && wr_set_valid) begin
            tag_ram[wr_index] <= wr_tag;
        end
    end

    always_comb begin
        rd_data = data_ram[{rd_index, rd_offset}];
        rd_hit  = valid[rd_index] && (tag_ram[rd_index] == rd_tag);
    end

endmodule

// File: rtl/cache_ctrl_wt.sv
// cache_ctrl_wt: direct-mapped, write-through, no-write-allocate cache controller.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : cache_ctrl_wt_if.slave
//              CPU  : cpu_read, cpu_write, cpu_addr, cpu_wdata -> cpu_rdata, stall
//              mem  : mem_read, mem_write, mem_addr, mem_wdata, mem_counter
//                     <- mem_ready, mem_rdata
// Read hits return data in the request cycle. A read miss refills the 4-word
// line through the mem_read/mem_counter handshake. Every store is sent to
// memory as a single-cycle mem_write pulse and updates the line only on a hit.
// Address fields come from cache_pkg helpers, so ADDR/INDEX_W must match the
// package geometry.
module cache_ctrl_wt
    import cache_pkg::*;
#(
    parameter int unsigned ADDR    = 10,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned INDEX_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    cache_ctrl_wt_if.slave bus
);

    state_t             state, state_n;
    logic [ADDR-1:0]    addr_q;
    logic [WIDTH-1:0]   wdata_q;
    logic [1:0]         counter_q;

    logic [ADDR-1:0]    lookup_addr;
    logic [WIDTH-1:0]   rd_data;
    logic               hit;

    logic               stall_c;
    logic [WIDTH-1:0]   cpu_rdata_c;
    logic               wr_en;
    logic [OFF_W-1:0]   wr_offset;
    logic [WIDTH-1:0]   wr_data;
    logic               wr_set_valid;
    logic [INDEX_W-1:0] wr_index;

    // IDLE looks up the live CPU address; WRITE re-checks the latched one.
    assign lookup_addr = (state == IDLE) ? bus.cpu_addr : addr_q;
    assign wr_index    = get_index(addr_q);

    cache_line_array #(
        .WIDTH (WIDTH)
    ) u_lines (
        .clk          (clk),
        .rst          (rst),
        .rd_index     (get_index(lookup_addr)),
        .rd_tag       (get_tag(lookup_addr)),
        .rd_offset    (lookup_addr[OFF_W-1:0]),
        .rd_data      (rd_data),
        .rd_hit       (hit),
        .wr_en        (wr_en),
        .wr_index     (wr_index),
        .wr_offset    (wr_offset),
        .wr_data      (wr_data),
        .wr_set_valid (wr_set_valid),
        .wr_tag       (get_tag(addr_q))
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n      = state;
        stall_c      = 1'b0;
        cpu_rdata_c  = '0;
        wr_en        = 1'b0;
        wr_offset    = addr_q[OFF_W-1:0];
        wr_data      = wdata_q;
        wr_set_valid = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cpu_write) begin
                    stall_c = 1'b1;
                    state_n = WRITE;
                end else if (bus.cpu_read) begin
                    if (hit) begin
                        cpu_rdata_c = rd_data;
                    end else begin
                        stall_c = 1'b1;
                        state_n = REFILL;
                    end
                end
            end
            REFILL: begin
                stall_c   = 1'b1;
                wr_en     = 1'b1;
                wr_offset = counter_q;
                wr_data   = bus.mem_rdata;
                if (bus.mem_ready && (counter_q == 2'd3)) begin
                    wr_set_valid = 1'b1;
                    state_n      = IDLE;
                end
            end
            WRITE: begin
                wr_en   = hit;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Request latches and refill word counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            counter_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cpu_write) begin
                        addr_q  <= bus.cpu_addr;
                        wdata_q <= bus.cpu_wdata;
                    end else if (bus.cpu_read && !hit) begin
                        addr_q    <= bus.cpu_addr;
                        counter_q <= '0;
                    end
                end
                REFILL: begin
                    // Hold at the last word until data_mem answers; early
                    // mem_ready is ignored because only counter 3 completes.
                    if (counter_q == 2'd3) begin
                        if (bus.mem_ready) begin
                            counter_q <= '0;
                        end
                    end else begin
                        counter_q <= counter_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Combinational CPU outputs are forced low while reset is held so the
    // whole output set reads zero regardless of a pending request.
    assign bus.stall       = stall_c & ~rst;
    assign bus.cpu_rdata   = rst ? '0 : cpu_rdata_c;
    assign bus.mem_read    = (state == REFILL);
    assign bus.mem_write   = (state == WRITE);
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.mem_counter = counter_q;

endmodule

// File: tb/tb_cache_ctrl_wt.sv
module tb_cache_ctrl_wt;

    localparam int TMO = 40;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   wr_pulses;
    logic [31:0] mem [1024];

    cache_ctrl_wt_if #(.ADDR(10), .WIDTH(32)) bus ();

    cache_ctrl_wt #(.ADDR(10), .WIDTH(32), .INDEX_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data_mem model: combinational refill word, ready on the last word,
    // store captured on the falling edge of the mem_write cycle.
    assign bus.mem_rdata = mem[{bus.mem_addr[9:2], bus.mem_counter}];
    assign bus.mem_ready = bus.mem_read && (bus.mem_counter == 2'd3);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        wr_pulses = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | i;
        mem[10'h04C] = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            if (bus.mem_write) begin
                mem[bus.mem_addr] = bus.mem_wdata;
                wr_pulses++;
            end
            if (!rst) chk("rd_wr_exclusive", {31'b0, bus.mem_read & bus.mem_write}, 32'h0);
        end
    end

    // Completes a read whose request is already being driven.
    task automatic finish_read(output logic [31:0] data, output int stalls,
                               output logic [7:0] trace, output logic [9:0] fill_addr);
        stalls    = 0;
        trace     = '0;
        fill_addr = '0;
        #1;
        while (bus.stall && stalls < TMO) begin
            if (bus.mem_read) begin
                trace     = {trace[5:0], bus.mem_counter};
                fill_addr = bus.mem_addr;
            end
            @(negedge clk);
            #1;
            stalls++;
        end
        data = bus.cpu_rdata;
        @(posedge clk);
        #1;
        bus.cpu_read = 1'b0;
    endtask

    task automatic do_read(input logic [9:0] a, output logic [31:0] data, output int stalls,
                           output logic [7:0] trace, output logic [9:0] fill_addr);
        @(negedge clk);
        bus.cpu_read = 1'b1;
        bus.cpu_addr = a;
        finish_read(data, stalls, trace, fill_addr);
    endtask

    task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic also_read,
                            output int stalls, output logic wr_seen, output logic saw_rd,
                            output int pulses);
        int p0;
        @(negedge clk);
        p0 = wr_pulses;
        bus.cpu_write = 1'b1;
        bus.cpu_read  = also_read;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        stalls = 0;
        saw_rd = 1'b0;
        #1;
        while (bus.stall && stalls < TMO) begin
            if (bus.mem_read) saw_rd = 1'b1;
            @(negedge clk);
            #1;
            stalls++;
        end
        if (bus.mem_read) saw_rd = 1'b1;
        wr_seen = bus.mem_write;
        @(posedge clk);
        #1;
        bus.cpu_write = 1'b0;
        bus.cpu_read  = 1'b0;
        @(negedge clk);
        #1;
        pulses = wr_pulses - p0;
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  tr;
        logic [9:0]  fa;
        logic        ws, sr;
        int          st, pl, n;

        checks = 0;
        errors = 0;
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        rst = 1'b1;
        #12;
        chk("rst_stall",     {31'b0, bus.stall},     32'h0);
        chk("rst_mem_read",  {31'b0, bus.mem_read},  32'h0);
        chk("rst_mem_write", {31'b0, bus.mem_write}, 32'h0);
        chk("rst_counter",   {30'b0, bus.mem_counter}, 32'h0);
        chk("rst_mem_addr",  {22'b0, bus.mem_addr},  32'h0);
        chk("rst_mem_wdata", bus.mem_wdata,          32'h0);
        chk("rst_cpu_rdata", bus.cpu_rdata,          32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Cold miss on 0x04C, then hit on the same line
        do_read(10'h04C, d, st, tr, fa);
        chk("miss04C_stalls", st, 5);
        chk("miss04C_data",   d, 32'hDEAD_BEEF);
        chk("miss04C_trace",  {24'b0, tr}, 32'h0000_001B);
        chk("miss04C_addr",   {22'b0, fa}, 32'h0000_004C);
        do_read(10'h04D, d, st, tr, fa);
        chk("hit04D_stalls", st, 0);
        chk("hit04D_data",   d, 32'hC0DE_004D);

        // Write hit updates memory and the cached word
        do_write(10'h04E, 32'h1234_5678, 1'b0, st, ws, sr, pl);
        chk("wr04E_stalls", st, 1);
        chk("wr04E_pulse",  {31'b0, ws}, 32'h1);
        chk("wr04E_npulse", pl, 1);
        chk("wr04E_noread", {31'b0, sr}, 32'h0);
        chk("wr04E_mem",    mem[10'h04E], 32'h1234_5678);
        do_read(10'h04E, d, st, tr, fa);
        chk("hit04E_stalls", st, 0);
        chk("hit04E_data",   d, 32'h1234_5678);

        // Write miss: memory only, no allocate
        do_write(10'h200, 32'hCAFE_F00D, 1'b0, st, ws, sr, pl);
        chk("wr200_stalls", st, 1);
        chk("wr200_npulse", pl, 1);
        chk("wr200_mem",    mem[10'h200], 32'hCAFE_F00D);
        do_read(10'h200, d, st, tr, fa);
        chk("rd200_stalls", st, 5);
        chk("rd200_data",   d, 32'hCAFE_F00D);

        // Conflict on index 4: tags 0 and 1 evict each other
        do_read(10'h010, d, st, tr, fa);
        chk("rd010_stalls", st, 5);
        chk("rd010_data",   d, 32'hC0DE_0010);
        do_read(10'h090, d, st, tr, fa);
        chk("rd090_stalls", st, 5);
        chk("rd090_data",   d, 32'hC0DE_0090);
        do_read(10'h010, d, st, tr, fa);
        chk("rd010b_stalls", st, 5);
        chk("rd010b_data",   d, 32'hC0DE_0010);

        // Read and write together on a hit address behave as a store
        do_write(10'h04D, 32'hA5A5_5A5A, 1'b1, st, ws, sr, pl);
        chk("rw04D_stalls", st, 1);
        chk("rw04D_pulse",  {31'b0, ws}, 32'h1);
        chk("rw04D_noread", {31'b0, sr}, 32'h0);
        chk("rw04D_npulse", pl, 1);
        chk("rw04D_mem",    mem[10'h04D], 32'hA5A5_5A5A);
        do_read(10'h04D, d, st, tr, fa);
        chk("hit04Db_stalls", st, 0);
        chk("hit04Db_data",   d, 32'hA5A5_5A5A);

        // Reset in the middle of a refill of 0x3A0
        @(negedge clk);
        bus.cpu_read = 1'b1;
        bus.cpu_addr = 10'h3A0;
        #1;
        n = 0;
        while (!(bus.mem_read && bus.mem_counter == 2'd2) && n < TMO) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rst_mid_reach", n, 3);
        rst = 1'b1;
        #1;
        chk("rstmid_stall",     {31'b0, bus.stall},     32'h0);
        chk("rstmid_mem_read",  {31'b0, bus.mem_read},  32'h0);
        chk("rstmid_mem_write", {31'b0, bus.mem_write}, 32'h0);
        chk("rstmid_counter",   {30'b0, bus.mem_counter}, 32'h0);
        chk("rstmid_mem_addr",  {22'b0, bus.mem_addr},  32'h0);
        chk("rstmid_mem_wdata", bus.mem_wdata,          32'h0);
        chk("rstmid_cpu_rdata", bus.cpu_rdata,          32'h0);
        @(negedge clk);
        rst = 1'b0;
        finish_read(d, st, tr, fa);
        chk("rd3A0_stalls", st, 5);
        chk("rd3A0_data",   d, 32'hC0DE_03A0);
        chk("rd3A0_trace",  {24'b0, tr}, 32'h0000_001B);

        // All lines invalid after reset: previously cached 0x04D misses
        do_read(10'h04D, d, st, tr, fa);
        chk("rd04Dpost_stalls", st, 5);
        chk("rd04Dpost_data",   d, 32'hA5A5_5A5A);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cache_ctrl_wt.md
# cache_ctrl_wt

Direct-mapped, write-through, no-write-allocate cache controller between the CPU load/store port and `data_mem`. Holds tag/valid/data arrays, serves read hits in zero wait cycles, and sequences 4-word block refills by driving `data_mem`'s `mem_read`/`counter` handshake. Every store is forwarded to memory as a single-cycle `mem_write` pulse. On a write hit the cached word is also updated.

## Interface
Parameters:
- `ADDR` = 10: word-address width, matches `data_mem`.
- `WIDTH` = 32: data word width.
- `INDEX_W` = 5: line index bits, giving 32 lines. Offset is fixed at 2 bits (4 words/line). Tag width is `ADDR-INDEX_W-2` = 3.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_read`  in  1  load request; held until `stall`=0.
- `cpu_write`  in  1  store request; held until `stall`=0.
- `cpu_addr`  in  ADDR  word address.
- `cpu_wdata`  in  WIDTH  store data.
- `cpu_rdata`  out  WIDTH  load data; valid when `cpu_read` and `stall`=0.
- `stall`  out  1  CPU must hold request and wait.
- `mem_read`  out  1  refill in progress, to `data_mem`.
- `mem_write`  out  1  one-cycle store pulse, to `data_mem`.
- `mem_addr`  out  ADDR  latched request address.
- `mem_wdata`  out  WIDTH  latched store data.
- `mem_counter`  out  2  refill word select.
- `mem_ready`  in  1  `data_mem` signals last refill word.
- `mem_rdata`  in  WIDTH  refill word from `data_mem`.

## Operation
- Address split: tag = `addr[ADDR-1:INDEX_W+2]`, index = `addr[INDEX_W+1:2]`, offset = `addr[1:0]`.
- Hit = `valid[index]` && tag match, evaluated combinationally in IDLE.
- FSM states:
  - **IDLE**
    - `cpu_write` (has priority if `cpu_read` is also high): assert `stall`, latch addr/data, go to WRITE.
    - `cpu_read` hit: `stall`=0, `cpu_rdata`=line word. Stay in IDLE.
    - `cpu_read` miss: assert `stall`, latch addr, clear `mem_counter`, go to REFILL.
  - **REFILL**
    - `mem_read`=1 and `stall`=1.
    - Each cycle, write `mem_rdata` into data[index][`mem_counter`] and increment `mem_counter`.
    - When `mem_ready`=1 (counter=3): write the last word, set `valid[index]`, store tag, clear counter, go to IDLE.
  - **WRITE**
    - `mem_write`=1 for exactly this cycle; `stall`=0 so the CPU retires the store.
    - If the latched address hits, update data[index][offset] with `mem_wdata`. A miss does not allocate.
    - Go to IDLE.
- `mem_read` and `mem_write` are never high together.
- `cpu_rdata` = 0 whenever not (IDLE && `cpu_read` && hit).
- Reset:
  - All valid bits cleared; data/tag arrays not cleared.
  - State → IDLE.
  - All outputs 0: `stall`, `mem_read`, `mem_write`, `mem_counter`, `mem_addr`, `mem_wdata`, `cpu_rdata`.
  - Reset during REFILL abandons the fill; the line stays invalid.

## Timing
- Read hit: 0 stall cycles; data available in the same cycle.
- Read miss:
  - Cycle 0: miss detected, `stall`=1.
  - Cycles 1–4: REFILL with `mem_counter` = 0, 1, 2, 3.
  - Cycle 5: IDLE, hit, `stall`=0, data returned.
  - Total: 5 stall cycles.
- Write (hit or miss): 1 stall cycle.
  - `mem_write` pulses in cycle 1; `data_mem` captures it on that cycle's falling edge.
- `mem_ready` before counter=3 is ignored. If `mem_ready` never arrives, the FSM stays in REFILL; there is no timeout.
- Request changes during `stall` are illegal. The controller uses only the latched address and data.

## Structure
- Package `cache_pkg`:
  - state enum `{IDLE, REFILL, WRITE}`;
  - localparams `TAG_W`, `OFF_W`=2, `LINES`=`1<<INDEX_W`;
  - functions `get_tag` and `get_index`.
- Sub-module `cache_line_array`:
  - holds the valid vector (async clear on `rst`), tag RAM and data RAM;
  - one write port (index, offset, data, `set_valid`, tag);
  - combinational read of the line word plus hit.
- `cache_ctrl_wt` contains the FSM, counter, latches and the `data_mem` interface.

## Test plan
- Cold read of addr 0x04C, memory word 0x04C = 0xDEADBEEF → 5 stall cycles, `mem_counter` steps 0–3 with addresses 0x04C–0x04F, `cpu_rdata`=0xDEADBEEF. A following read of 0x04D hits with 0 stalls.
- Write 0x12345678 to 0x04E after that line is filled → one `mem_write` pulse, memory[0x04E] updated. A following read of 0x04E hits and returns 0x12345678.
- Write to uncached 0x200 → `mem_write` pulse, memory updated. A following read of 0x200 misses and refills (no allocate).
- Conflict: fill 0x010, then read 0x090 (same index, different tag) → miss, refill replaces the line. Read 0x010 misses again.
- Assert `rst` at `mem_counter`=2 of a refill → all outputs 0 immediately. Re-reading the same address performs a full 5-cycle miss.
- `cpu_read` and `cpu_write` high together on a hit address → treated as a store: `mem_write` pulses, `mem_read` stays 0.
